// File: rtl/mem_tx_scheduler_pkg.sv
// Shared definitions for the serial memory-port scheduler: command
// encodings, requester tags and the FSM state types.
package mem_tx_scheduler_pkg;

  localparam int TX_CMD_BITS = 4;

  // Every header has bit0 set so its first pin cycle is nonzero.
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 4'b0001;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 4'b0011;

  // Requester tags stored in the outstanding-read queue.
  localparam logic TAG_PF = 1'b0;
  localparam logic TAG_DT = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HEADER,
    TX_ADDR,
    TX_WDATA
  } tx_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_DATA
  } rx_state_e;

  // Only reads are answered on rx_pins.
  function automatic logic has_response(input logic [TX_CMD_BITS-1:0] cmd);
    return cmd == TX_HEADER_READ_16;
  endfunction

endpackage

// File: rtl/mem_tx_scheduler_tag_fifo.sv
// In-order queue of requester tags for reads still awaiting a response.
// Shift-register FIFO: entry 0 is always the head.
module mem_tx_scheduler_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head,
  output logic empty,
  output logic full
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Pop shifts toward the head first, so a simultaneous push lands behind it.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop && cnt_q != '0) begin
      mem_d = mem_q >> 1;
      cnt_d = cnt_q - CW'(1);
    end
    if (push && cnt_d != CW'(DEPTH)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_d == CW'(i)) mem_d[i] = push_tag;
      end
      cnt_d = cnt_d + CW'(1);
    end
  end

  // Occupancy is control state; entry contents are meaningless when empty.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[0];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/mem_tx_scheduler.sv
// Two-requester scheduler for a single serial memory port: arbitrates
// commands, serialises header and payload onto tx_pins, and routes each
// response on rx_pins back to the requester whose read it answers.
module mem_tx_scheduler
  import mem_tx_scheduler_pkg::*;
#(
  parameter int IO_BITS        = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int HEADER_CYCLES  = 2,
  parameter int MAX_READS      = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pf_cmd_valid,
  output logic                              pf_started,
  input  logic [IO_BITS-1:0]                pf_data,
  output logic                              pf_data_next,
  input  logic                              dt_cmd_valid,
  input  logic [TX_CMD_BITS-1:0]            dt_cmd,
  output logic                              dt_started,
  input  logic [IO_BITS-1:0]                dt_data,
  output logic                              dt_data_next,
  output logic [$clog2(PAYLOAD_CYCLES):0]   tx_counter,
  output logic                              tx_done,
  output logic [IO_BITS-1:0]                tx_pins,
  input  logic [IO_BITS-1:0]                rx_pins,
  output logic [IO_BITS-1:0]                rx_sbs,
  output logic [$clog2(PAYLOAD_CYCLES):0]   rx_counter,
  output logic                              pf_rx_data_valid,
  output logic                              dt_rx_data_valid,
  output logic                              pf_rx_done,
  output logic                              dt_rx_done,
  output logic                              busy
);

  localparam int CNT_W = $clog2(PAYLOAD_CYCLES) + 1;

  tx_state_e                tx_state_q, tx_state_d;
  logic [CNT_W-1:0]         tx_cnt_q, tx_cnt_d;
  logic [TX_CMD_BITS-1:0]   cmd_q, cmd_d;
  logic                     owner_q, owner_d;
  logic                     rr_last_q, rr_last_d;
  rx_state_e                rx_state_q, rx_state_d;
  logic [CNT_W-1:0]         rx_cnt_q, rx_cnt_d;
  logic [IO_BITS-1:0]       rx_sbs_q, rx_sbs_d;

  logic q_push, q_push_tag, q_pop, q_head, q_empty, q_full;
  logic pf_elig, dt_elig, arb_open, tx_last, rx_last;

  mem_tx_scheduler_tag_fifo #(.DEPTH(MAX_READS)) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (q_push),
    .push_tag (q_push_tag),
    .pop      (q_pop),
    .head     (q_head),
    .empty    (q_empty),
    .full     (q_full)
  );

  // Reads need a free tag slot (pre-pop occupancy); writes never do.
  assign pf_elig = pf_cmd_valid && !q_full;
  assign dt_elig = dt_cmd_valid && (!has_response(dt_cmd) || !q_full);
  assign tx_last = (tx_cnt_q == CNT_W'(PAYLOAD_CYCLES - 1));
  assign rx_last = (rx_cnt_q == CNT_W'(PAYLOAD_CYCLES - 1));

  // TX sequencing and arbitration; a grant may overlap the final payload cycle.
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    cmd_d        = cmd_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    tx_pins      = '0;
    tx_counter   = '0;
    tx_done      = 1'b0;
    pf_data_next = 1'b0;
    dt_data_next = 1'b0;
    pf_started   = 1'b0;
    dt_started   = 1'b0;
    q_push       = 1'b0;
    q_push_tag   = TAG_PF;
    arb_open     = 1'b0;
    case (tx_state_q)
      TX_IDLE: arb_open = 1'b1;
      TX_HEADER: begin
        for (int k = 0; k < HEADER_CYCLES; k++) begin
          if (tx_cnt_q == CNT_W'(k)) tx_pins = cmd_q[k*IO_BITS +: IO_BITS];
        end
        if (tx_cnt_q == CNT_W'(HEADER_CYCLES - 1)) begin
          tx_state_d = TX_ADDR;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_ADDR, TX_WDATA: begin
        tx_pins      = (owner_q == TAG_DT) ? dt_data : pf_data;
        pf_data_next = (owner_q == TAG_PF);
        dt_data_next = (owner_q == TAG_DT);
        tx_counter   = tx_cnt_q;
        if (tx_last) begin
          tx_cnt_d = '0;
          if (tx_state_q == TX_ADDR && !has_response(cmd_q)) begin
            tx_state_d = TX_WDATA;
          end else begin
            tx_done    = 1'b1;
            tx_state_d = TX_IDLE;
            arb_open   = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (arb_open && (pf_elig || dt_elig)) begin
      if (dt_elig && (!pf_elig || rr_last_q == TAG_PF)) begin
        dt_started = 1'b1;
        owner_d    = TAG_DT;
        cmd_d      = dt_cmd;
      end else begin
        pf_started = 1'b1;
        owner_d    = TAG_PF;
        cmd_d      = TX_HEADER_READ_16;
      end
      rr_last_d  = owner_d;
      tx_state_d = TX_HEADER;
      tx_cnt_d   = '0;
      q_push     = has_response(cmd_d);
      q_push_tag = owner_d;
    end
  end

  // RX response tracking; the head tag selects the receiving requester.
  always_comb begin
    rx_state_d       = rx_state_q;
    rx_cnt_d         = rx_cnt_q;
    rx_sbs_d         = rx_sbs_q;
    rx_counter       = '0;
    pf_rx_data_valid = 1'b0;
    dt_rx_data_valid = 1'b0;
    pf_rx_done       = 1'b0;
    dt_rx_done       = 1'b0;
    q_pop            = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_pins != '0 && !q_empty) begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = '0;
          rx_sbs_d   = rx_pins;
        end
      end
      RX_DATA: begin
        rx_counter       = rx_cnt_q;
        pf_rx_data_valid = (q_head == TAG_PF);
        dt_rx_data_valid = (q_head == TAG_DT);
        if (rx_last) begin
          pf_rx_done = (q_head == TAG_PF);
          dt_rx_done = (q_head == TAG_DT);
          q_pop      = 1'b1;
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      rr_last_q  <= TAG_PF;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_sbs_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      rr_last_q  <= rr_last_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sbs_q   <= rx_sbs_d;
    end
  end

  // Latched command and owner; only read while a command is in flight.
  always_ff @(posedge clk) begin
    cmd_q   <= cmd_d;
    owner_q <= owner_d;
  end

  assign rx_sbs = rx_sbs_q;
  assign busy   = (tx_state_q != TX_IDLE) || !q_empty;

endmodule

// File: tb/tb_mem_tx_scheduler.sv
// Self-checking bench for mem_tx_scheduler: directed scenarios plus random
// traffic, checked every cycle against a transaction-offset model.
module tb_mem_tx_scheduler;
  import mem_tx_scheduler_pkg::*;

  localparam int IO = 2, PC = 8, HC = 2, MAXR = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic pf_cmd_valid, dt_cmd_valid;
  logic [TX_CMD_BITS-1:0] dt_cmd;
  logic [IO-1:0] pf_data, dt_data, rx_pins;
  logic pf_started, pf_data_next, dt_started, dt_data_next, tx_done;
  logic [3:0] tx_counter, rx_counter;
  logic [IO-1:0] tx_pins, rx_sbs;
  logic pf_rx_data_valid, dt_rx_data_valid, pf_rx_done, dt_rx_done, busy;

  always #5 clk = ~clk;

  mem_tx_scheduler #(.IO_BITS(IO), .PAYLOAD_CYCLES(PC), .HEADER_CYCLES(HC), .MAX_READS(MAXR)) dut (
    .clk(clk), .reset(reset),
    .pf_cmd_valid(pf_cmd_valid), .pf_started(pf_started), .pf_data(pf_data), .pf_data_next(pf_data_next),
    .dt_cmd_valid(dt_cmd_valid), .dt_cmd(dt_cmd), .dt_started(dt_started), .dt_data(dt_data),
    .dt_data_next(dt_data_next), .tx_counter(tx_counter), .tx_done(tx_done), .tx_pins(tx_pins),
    .rx_pins(rx_pins), .rx_sbs(rx_sbs), .rx_counter(rx_counter),
    .pf_rx_data_valid(pf_rx_data_valid), .dt_rx_data_valid(dt_rx_data_valid),
    .pf_rx_done(pf_rx_done), .dt_rx_done(dt_rx_done), .busy(busy)
  );

  logic [21:0] obs, exp_v;
  assign obs = {pf_started, pf_data_next, dt_started, dt_data_next, tx_counter, tx_done, tx_pins,
                rx_sbs, rx_counter, pf_rx_data_valid, dt_rx_data_valid, pf_rx_done, dt_rx_done, busy};

  int n_cmp = 0, n_fail = 0;

  // Model: a command in flight is described by its offset since grant.
  int m_tx_off, m_tx_len, m_rx_off;
  bit m_tx_own, m_rr;
  logic [TX_CMD_BITS-1:0] m_tx_cmd;
  bit m_q[$];
  logic [IO-1:0] m_sbs;
  logic e_gpf, e_gdt;
  bit resp_en, junk_en;
  logic [15:0] resp_payload;
  logic [15:0] pay_q[$];

  function automatic void model_reset();
    m_tx_off = -1; m_tx_len = 0; m_rx_off = -1; m_rr = 0; m_sbs = '0;
    m_q.delete();
  endfunction

  function automatic void model_eval();
    logic done, arb, pf_el, dt_el, dn_pf, dn_dt, rv_pf, rv_dt, rd_pf, rd_dt, bsy;
    logic [IO-1:0] pins;
    int cnt, rcnt;
    done = 0; dn_pf = 0; dn_dt = 0; rv_pf = 0; rv_dt = 0; rd_pf = 0; rd_dt = 0;
    pins = '0; cnt = 0; rcnt = 0;
    if (m_tx_off >= 0) begin
      done = (m_tx_off == m_tx_len - 1);
      if (m_tx_off < HC) pins = IO'(m_tx_cmd >> (IO * m_tx_off));
      else begin
        cnt = (m_tx_off - HC) % PC;
        if (m_tx_own) begin pins = dt_data; dn_dt = 1; end
        else begin pins = pf_data; dn_pf = 1; end
      end
    end
    arb   = (m_tx_off < 0) || done;
    pf_el = pf_cmd_valid && (m_q.size() < MAXR);
    dt_el = dt_cmd_valid && ((dt_cmd == TX_HEADER_WRITE_16) || (m_q.size() < MAXR));
    e_gpf = arb && pf_el && (!dt_el || m_rr);
    e_gdt = arb && dt_el && (!pf_el || !m_rr);
    if (m_rx_off >= 0) begin
      rcnt = m_rx_off;
      rv_pf = !m_q[0]; rv_dt = m_q[0];
      rd_pf = rv_pf && (m_rx_off == PC - 1);
      rd_dt = rv_dt && (m_rx_off == PC - 1);
    end
    bsy = (m_tx_off >= 0) || (m_q.size() != 0);
    exp_v = {e_gpf, dn_pf, e_gdt, dn_dt, 4'(cnt), done, pins, m_sbs, 4'(rcnt),
             rv_pf, rv_dt, rd_pf, rd_dt, bsy};
  endfunction

  function automatic void model_commit();
    if (reset) begin model_reset(); return; end
    if (m_rx_off >= 0) begin
      if (m_rx_off == PC - 1) begin void'(m_q.pop_front()); m_rx_off = -1; end
      else m_rx_off++;
    end else if (rx_pins != '0 && m_q.size() != 0) begin
      m_rx_off = 0; m_sbs = rx_pins;
      resp_payload = (pay_q.size() != 0) ? pay_q.pop_front() : 16'($urandom);
    end
    if (m_tx_off >= 0) m_tx_off = (m_tx_off == m_tx_len - 1) ? -1 : m_tx_off + 1;
    if (e_gpf || e_gdt) begin
      m_tx_own = e_gdt;
      m_tx_cmd = e_gdt ? dt_cmd : TX_HEADER_READ_16;
      m_tx_len = (m_tx_cmd == TX_HEADER_WRITE_16) ? HC + 2 * PC : HC + PC;
      m_tx_off = 0;
      m_rr = e_gdt;
      if (m_tx_cmd == TX_HEADER_READ_16) m_q.push_back(e_gdt);
    end
  endfunction

  task automatic advance();
    @(posedge clk); model_commit(); @(negedge clk);
  endtask

  task automatic idle_inputs();
    pf_cmd_valid = 0; dt_cmd_valid = 0; dt_cmd = TX_HEADER_READ_16; pf_data = '0; dt_data = '0;
  endtask

  // Memory side: answers outstanding reads when enabled, or sprays noise at an empty queue.
  task automatic mem_drive();
    if (m_rx_off >= 0) rx_pins = IO'(resp_payload >> (IO * m_rx_off));
    else if (resp_en && m_q.size() != 0) rx_pins = IO'($urandom_range(1, 3));
    else if (junk_en && m_q.size() == 0) rx_pins = IO'($urandom_range(0, 3));
    else rx_pins = '0;
  endtask

  task automatic drain();
    int c = 0;
    idle_inputs(); resp_en = 1;
    while ((m_tx_off >= 0 || m_q.size() != 0 || m_rx_off >= 0) && c < 400) begin
      mem_drive(); #1; model_eval();
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL drain c%0d got=%h want=%h", c, obs, exp_v); end
      advance(); c++;
    end
    resp_en = 0; rx_pins = '0; #1;
    n_cmp++; if (c >= 400 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle cycles=%0d busy=%b want<400,0", c, busy); end
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); rx_pins = '0; resp_en = 0; junk_en = 0;
    advance(); advance();
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      #1; model_eval();
      n_cmp++; if (obs !== '0) begin n_fail++; $display("FAIL reset_state c%0d got=%h want=0", c, obs); end
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL reset_model c%0d got=%h want=%h", c, obs, exp_v); end
      advance();
    end
  endtask

  task automatic test_pf_single();
    logic [15:0] addr = 16'h1234;
    int g = -1, d = -1, nx = 0;
    for (int c = 0; c < 16; c++) begin
      pf_cmd_valid = (c == 0);
      pf_data = (m_tx_off >= HC) ? IO'(addr >> (IO * ((m_tx_off - HC) % PC))) : '0;
      rx_pins = '0; #1; model_eval();
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL pf_single c%0d got=%h want=%h", c, obs, exp_v); end
      if (pf_started && g < 0) g = c;
      if (tx_done && d < 0) d = c;
      if (pf_data_next) nx++;
      advance();
    end
    n_cmp++; if (g != 0 || d != HC + PC || nx != PC) begin
      n_fail++; $display("FAIL pf_single_timing grant=%0d done=%0d next=%0d want 0,%0d,%0d", g, d, nx, HC + PC, PC);
    end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pf_single_outstanding busy=%b want 1", busy); end
    drain();
  endtask

  task automatic test_arb_alternate();
    bit seq[$], gap_ok[$];
    int c = 0;
    reset = 1; idle_inputs(); advance(); reset = 0;
    while (seq.size() < 4 && c < 200) begin
      pf_cmd_valid = 1; dt_cmd_valid = 1; dt_cmd = TX_HEADER_WRITE_16;
      pf_data = IO'($urandom); dt_data = IO'($urandom); rx_pins = '0;
      #1; model_eval();
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL arb_alt c%0d got=%h want=%h", c, obs, exp_v); end
      if (pf_started || dt_started) begin seq.push_back(dt_started); gap_ok.push_back(tx_done); end
      advance(); c++;
    end
    idle_inputs();
    n_cmp++; if (seq.size() != 4) begin n_fail++; $display("FAIL arb_alt_grants got=%0d want 4", seq.size()); end
    for (int k = 0; k < seq.size(); k++) begin
      n_cmp++; if (seq[k] != ((k % 2) == 0)) begin n_fail++; $display("FAIL arb_alt_order k%0d dt=%0d want %0d", k, seq[k], (k % 2) == 0); end
      if (k > 0) begin
        n_cmp++; if (!gap_ok[k]) begin n_fail++; $display("FAIL arb_alt_gap k%0d tx_done_at_grant=%0d want 1", k, gap_ok[k]); end
      end
    end
    drain();
  endtask

  task automatic test_write();
    int d = -1, nx = 0;
    logic b_after = 1'bx;
    for (int c = 0; c < 22; c++) begin
      dt_cmd_valid = (c == 0); dt_cmd = TX_HEADER_WRITE_16; dt_data = IO'($urandom); rx_pins = '0;
      #1; model_eval();
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL write c%0d got=%h want=%h", c, obs, exp_v); end
      if (tx_done && d < 0) d = c;
      if (dt_data_next) nx++;
      if (c == HC + 2 * PC + 1) b_after = busy;
      advance();
    end
    idle_inputs();
    n_cmp++; if (d != HC + 2 * PC || nx != 2 * PC || b_after !== 1'b0) begin
      n_fail++; $display("FAIL write_shape done=%0d next=%0d busy_after=%b want %0d,%0d,0", d, nx, b_after, HC + 2 * PC, 2 * PC);
    end
  endtask

  task automatic test_full();
    int grants = 0, r = -1, g3 = -1, c = 0;
    resp_en = 0;
    while (g3 < 0 && c < 150) begin
      pf_cmd_valid = 1; pf_data = IO'($urandom);
      if (c == 30) resp_en = 1;
      mem_drive(); #1; model_eval();
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL full c%0d got=%h want=%h", c, obs, exp_v); end
      if (pf_rx_done && r < 0) r = c;
      if (pf_started) begin grants++; if (grants == 3) g3 = c; end
      advance(); c++;
    end
    idle_inputs();
    n_cmp++; if (r < 0 || g3 != r + 1) begin n_fail++; $display("FAIL full_hold third_grant=%0d first_rx_done=%0d want grant=done+1", g3, r); end
    drain();
  endtask

  task automatic test_rx_order();
    bit dt_got = 0;
    bit dseq[$];
    int npf = 0, ndt = 0;
    resp_en = 0; pay_q.delete();
    for (int c = 0; c < 70; c++) begin
      pf_cmd_valid = (c == 0);
      dt_cmd_valid = (c > 0) && !dt_got; dt_cmd = TX_HEADER_READ_16;
      pf_data = IO'($urandom); dt_data = IO'($urandom);
      if (c == 25) begin pay_q.push_back(16'hBEEF); pay_q.push_back(16'h0F0F); resp_en = 1; end
      mem_drive(); #1; model_eval();
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL rx_order c%0d got=%h want=%h", c, obs, exp_v); end
      if (dt_started) dt_got = 1;
      if (pf_rx_data_valid) npf++;
      if (dt_rx_data_valid) ndt++;
      if (pf_rx_done || dt_rx_done) dseq.push_back(dt_rx_done);
      advance();
    end
    idle_inputs(); resp_en = 0;
    n_cmp++; if (dseq.size() != 2 || dseq[0] != 0 || dseq[1] != 1 || npf != PC || ndt != PC) begin
      n_fail++; $display("FAIL rx_order_route dones=%0d pf_cyc=%0d dt_cyc=%0d want 2,%0d,%0d pf-first", dseq.size(), npf, ndt, PC, PC);
    end
    drain();
  endtask

  task automatic test_rx_empty();
    for (int c = 0; c < 6; c++) begin
      rx_pins = IO'(c % 3 + 1); #1; model_eval();
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL rx_empty c%0d got=%h want=%h", c, obs, exp_v); end
      n_cmp++; if ({pf_rx_data_valid, dt_rx_data_valid, pf_rx_done, dt_rx_done, busy} !== 5'b0 || rx_counter !== 4'd0) begin
        n_fail++; $display("FAIL rx_empty_strobes c%0d got=%b/%0d want 0/0", c,
                           {pf_rx_data_valid, dt_rx_data_valid, pf_rx_done, dt_rx_done, busy}, rx_counter);
      end
      advance();
    end
    rx_pins = '0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 6; c++) begin
      pf_cmd_valid = (c == 0); pf_data = IO'($urandom); rx_pins = '0;
      #1; model_eval();
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL reset_mid_pre c%0d got=%h want=%h", c, obs, exp_v); end
      advance();
    end
    n_cmp++; if (pf_data_next !== 1'b1) begin n_fail++; $display("FAIL reset_mid_in_addr pf_data_next=%b want 1", pf_data_next); end
    reset = 1; advance(); reset = 0;
    for (int c = 0; c < 4; c++) begin
      rx_pins = (c == 0) ? '0 : 2'b01; #1; model_eval();
      n_cmp++; if (obs !== '0) begin n_fail++; $display("FAIL reset_mid_clear c%0d got=%h want=0", c, obs); end
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL reset_mid_model c%0d got=%h want=%h", c, obs, exp_v); end
      advance();
    end
    rx_pins = '0;
  endtask

  task automatic test_random();
    junk_en = 1;
    for (int c = 0; c < 3000; c++) begin
      pf_cmd_valid = ($urandom_range(0, 3) == 0);
      dt_cmd_valid = ($urandom_range(0, 3) == 0);
      dt_cmd = $urandom_range(0, 1) ? TX_HEADER_WRITE_16 : TX_HEADER_READ_16;
      pf_data = IO'($urandom); dt_data = IO'($urandom);
      resp_en = ($urandom_range(0, 4) != 0);
      mem_drive(); #1; model_eval();
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL random c%0d got=%h want=%h", c, obs, exp_v); end
      advance();
    end
    junk_en = 0;
    drain();
  endtask

  initial begin
    model_reset();
    idle_inputs(); rx_pins = '0; resp_en = 0; junk_en = 0; resp_payload = '0;
    e_gpf = 0; e_gdt = 0;
    @(negedge clk);
    test_reset();
    test_pf_single();
    test_arb_alternate();
    test_write();
    test_full();
    test_rx_order();
    test_rx_empty();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_tx_scheduler.md
Name: mem_tx_scheduler

Overview:
- Shares the single serial memory port between two requesters: the prefetcher (instruction reads) and the load/store unit (data reads and writes).
- Arbitrates TX commands and sequences the header and payload cycles onto tx_pins.
- Keeps an in-order tag queue of outstanding reads, and uses it to route each RX response to the requester that issued it.
- Produces the requester-qualified started, data_next, data_valid and done strobes.

Parameters:
- IO_BITS, 2, pin width per cycle
- PAYLOAD_CYCLES, 8, cycles per 16-bit payload
- HEADER_CYCLES, 2, cycles per command header (TX_CMD_BITS/IO_BITS)
- MAX_READS, 2, maximum outstanding reads (tag queue depth)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- pf_cmd_valid  in  1  prefetcher requests a READ_16
- pf_started  out  1  pulse: prefetch command won arbitration
- pf_data  in  IO_BITS  prefetcher payload bits (address)
- pf_data_next  out  1  pf_data consumed this cycle
- dt_cmd_valid  in  1  load/store request
- dt_cmd  in  TX_CMD_BITS  READ_16 or WRITE_16 header
- dt_started  out  1  pulse: data command won
- dt_data  in  IO_BITS  data payload bits
- dt_data_next  out  1  dt_data consumed this cycle
- tx_counter  out  $clog2(PAYLOAD_CYCLES)+1  payload cycle index within the command
- tx_done  out  1  last payload cycle of a command
- tx_pins  out  IO_BITS  serial output; 0 when idle
- rx_pins  in  IO_BITS  serial input; 0 when idle
- rx_sbs  out  IO_BITS  start-cycle bits of the current response
- rx_counter  out  $clog2(PAYLOAD_CYCLES)+1  RX payload index
- pf_rx_data_valid / dt_rx_data_valid  out  1  rx_pins carries payload for that requester
- pf_rx_done / dt_rx_done  out  1  last payload cycle for that requester
- busy  out  1  TX not idle or reads outstanding

Behaviour:
- Reset: TX FSM to IDLE, tag queue empty, rr_last=pf. All strobes 0, tx_pins 0, counters 0, busy 0.
- TX FSM states: IDLE -> HEADER (HEADER_CYCLES) -> ADDR (PAYLOAD_CYCLES) -> [WDATA (PAYLOAD_CYCLES), WRITE_16 only] -> IDLE.
- IDLE arbitration, per cycle. A read is eligible only while the tag queue is not full. Write eligibility ignores the queue.
  - If both requesters are eligible, the grant goes opposite to rr_last. rr_last updates on every grant.
  - The grant cycle pulses pf_started or dt_started; HEADER begins the next cycle.
  - Granted commands are latched; requester valids are don't-care after grant.
- HEADER: drives the latched header LSB-first. Every command encoding has bit0=1, so the first header cycle is nonzero and marks the start.
- ADDR/WDATA: tx_pins = granted requester's data combinationally. That requester's *_data_next is high every cycle. tx_counter counts 0..PAYLOAD_CYCLES-1 within each payload phase; tx_done is high on the final cycle of the command.
- Back-to-back: a new grant may occur in the tx_done cycle, so HEADER follows with zero idle cycles.
- Tag queue:
  - A read pushes its tag (pf=0, dt=1) in the grant cycle.
  - Pop on the last RX payload cycle.
  - Push and pop in the same cycle while full are allowed; the full check uses the pre-pop count.
- RX FSM states: RIDLE -> RDATA.
  - Start: rx_pins != 0 while in RIDLE with the queue non-empty. rx_sbs latches that value. rx_pins != 0 with an empty queue is ignored (no state change).
  - RDATA lasts PAYLOAD_CYCLES cycles. The head-tag requester's rx_data_valid is high; rx_counter is 0..PAYLOAD_CYCLES-1; *_rx_done is high on the last cycle. Then RIDLE.
  - A response start in the same cycle as the preceding rx_done is not accepted; one idle cycle minimum.
- TX and RX run independently; a response may arrive while a command is being sent.
- Reset mid-transfer aborts both FSMs and clears the queue immediately. The external port is assumed reset with it.

Decomposition:
- Shared package / common.vh: TX_CMD_BITS, TX_HEADER_READ_16, TX_HEADER_WRITE_16, tag encodings, and a has_response() helper.
- One sub-module: tag_fifo (shift-register FIFO, 1-bit entries, depth MAX_READS).

Test Plan:
- pf_cmd_valid alone, pf_data=addr 0x1234 -> pf_started 1 cycle; header cycles, then 8 cycles tx_pins=pf_data with pf_data_next high; tx_done on cycle 7; queue count 1.
- Both valid each cycle from reset (rr_last=pf) -> grants alternate dt, pf, dt, pf; no gap between tx_done and the next HEADER.
- dt WRITE_16 -> header + 8 addr + 8 data cycles; no tag pushed; busy drops after tx_done.
- Two pf reads then a third pf request (MAX_READS=2) -> third held in IDLE until the first response's pf_rx_done, then granted.
- Outstanding order pf then dt; two responses with payloads 0xBEEF, 0x0F0F -> pf_rx_data_valid for the first 8 cycles, dt_rx_data_valid for the second; rx_counter 0..7 each.
- rx_pins=1 with an empty queue -> no strobes. Reset asserted mid-ADDR -> all outputs 0 on the next cycle and the queue empty.
